// File: rtl/mem_responder_if.sv
// Request/response bus between the core's memory port and mem_responder.
// One request outstanding at a time; mem_rdata/mem_err mean something only while mem_done=1.
interface mem_responder_if;
  logic        mem_rden;
  logic        mem_wren;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_err;
  logic        tohost_valid;
  logic [31:0] tohost_data;

  modport master (
    output mem_rden, mem_wren, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_done, mem_err, tohost_valid, tohost_data
  );

  modport slave (
    input  mem_rden, mem_wren, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_done, mem_err, tohost_valid, tohost_data
  );
endinterface

// File: rtl/mem_responder.sv
// Word-organised RAM responder: IDLE/WAIT/RESP FSM, completion pulse after WAIT_STATES extra cycles.
// MEM_RESPONDER_MMIO_EN maps a tohost register at byte address MMIO_ADDR; INIT_FILE names the preload image.
// Handshake: a request (mem_rden|mem_wren) is taken in IDLE or RESP; mem_done pulses one cycle per request.
module mem_responder #(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 0,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] MMIO_ADDR   = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus_if,
  output logic [1:0]      dbg_state_o
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0] ram [DEPTH];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [31:0] tohost_q, tohost_d;

  logic          req;
  logic          accept;
  logic          in_resp;
  logic          range_err;
  logic          mmio_hit;
  logic [AW-1:0] widx;
  logic [31:0]   merged;

  assign req       = bus_if.mem_rden | bus_if.mem_wren;
  assign accept    = req && ((state_q == S_IDLE) || (state_q == S_RESP));
  assign in_resp   = (state_q == S_RESP);
  assign widx      = addr_q[AW+1:2];
  assign range_err = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);

`ifdef MEM_RESPONDER_MMIO_EN
  assign mmio_hit = (addr_q == MMIO_ADDR);
`else
  assign mmio_hit = 1'b0;
`endif

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = wstrb_q[b] ? wdata_q[8*b +: 8] : ram[widx][8*b +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    tohost_d = tohost_q;
    if (state_q == S_WAIT) begin
      if (cnt_q == 4'd0) state_d = S_RESP;
      else               cnt_d   = cnt_q - 4'd1;
    end else if (in_resp) begin
      state_d = S_IDLE;
    end
    if (in_resp && wr_q && mmio_hit) tohost_d = wdata_q;
    if (accept) begin
      addr_d  = bus_if.mem_addr;
      wdata_d = bus_if.mem_wdata;
      wstrb_d = bus_if.mem_wstrb;
      wr_d    = bus_if.mem_wren;
      rd_d    = bus_if.mem_rden & ~bus_if.mem_wren;
      if (WAIT_STATES > 0) begin
        state_d = S_WAIT;
        cnt_d   = 4'(WAIT_STATES - 1);
      end else begin
        state_d = S_RESP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      tohost_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      tohost_q <= tohost_d;
    end
  end

  // Write lands on the edge that ends RESP, so a read accepted in RESP sees it.
  always_ff @(posedge clk) begin
    if (in_resp && wr_q && !mmio_hit && !range_err) ram[widx] <= merged;
  end

  always_comb begin
    bus_if.mem_done     = in_resp;
    bus_if.mem_err      = in_resp && !mmio_hit && range_err;
    bus_if.mem_rdata    = 32'd0;
    bus_if.tohost_valid = in_resp && mmio_hit && wr_q;
    bus_if.tohost_data  = tohost_q;
    if (in_resp && rd_q) begin
      if (mmio_hit)        bus_if.mem_rdata = tohost_q;
      else if (!range_err) bus_if.mem_rdata = ram[widx];
    end
  end

  assign dbg_state_o = state_q;
endmodule
